// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the IF/LS requesters, the SRAM port arbiter and the SRAM wrapper.
// The arbiter uses the slave modport; the pipeline/SRAM side uses master.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              sram_wea;
  logic [ADDR_W-1:0] sram_waddr;
  logic [DATA_W-1:0] sram_dina;
  logic [ADDR_W-1:0] sram_addra;
  logic [DATA_W-1:0] sram_douta;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, sram_douta,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           sram_wea, sram_waddr, sram_dina, sram_addra
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, sram_douta,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           sram_wea, sram_waddr, sram_dina, sram_addra
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: LS has fixed priority, IF wins after MAX_STARVE denied cycles.
// Define SRAM_ARB_PERF_EN to add the perf_conflict / perf_if_stall counters.
//   state    | meaning
//   OWN_NONE | no read response due this cycle
//   OWN_IF   | rdata_q holds the IF read granted last cycle
//   OWN_LS   | rdata_q holds the LS read granted last cycle
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic                clka,
  input  logic                rstb,
  sram_port_arbiter_if.slave  bus
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_conflict,
  output logic [31:0]         perf_if_stall
`endif
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_e;

  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

  owner_e            rsp_owner_q, rsp_owner_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              if_gnt, ls_gnt, rd_gnt;

  always_comb begin
    if_gnt       = bus.if_req & (~bus.ls_req | (starve_cnt_q == STARVE_LIMIT));
    ls_gnt       = bus.ls_req & ~if_gnt;
    rd_gnt       = if_gnt | (ls_gnt & ~bus.ls_we);

    rsp_owner_d  = OWN_NONE;
    if (if_gnt) begin
      rsp_owner_d = OWN_IF;
    end else if (ls_gnt && !bus.ls_we) begin
      rsp_owner_d = OWN_LS;
    end

    rdata_d      = rd_gnt ? bus.sram_douta : rdata_q;

    starve_cnt_d = '0;
    if (bus.if_req && !if_gnt) begin
      starve_cnt_d = (starve_cnt_q == STARVE_LIMIT) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clka or posedge rstb) begin
    if (rstb) begin
      rsp_owner_q  <= OWN_NONE;
      starve_cnt_q <= '0;
      rdata_q      <= '0;
    end else begin
      rsp_owner_q  <= rsp_owner_d;
      starve_cnt_q <= starve_cnt_d;
      rdata_q      <= rdata_d;
    end
  end

  // Idle cycles park the SRAM port at all-zero so nothing downstream sees stale addresses.
  assign bus.if_gnt     = if_gnt;
  assign bus.ls_gnt     = ls_gnt;
  assign bus.sram_addra = if_gnt ? bus.if_addr : (ls_gnt ? bus.ls_addr : '0);
  assign bus.sram_waddr = if_gnt ? bus.if_addr : (ls_gnt ? bus.ls_addr : '0);
  assign bus.sram_wea   = ls_gnt & bus.ls_we;
  assign bus.sram_dina  = ls_gnt ? bus.ls_wdata : '0;

  assign bus.if_rvalid  = (rsp_owner_q == OWN_IF);
  assign bus.ls_rvalid  = (rsp_owner_q == OWN_LS);
  assign bus.if_rdata   = (rsp_owner_q == OWN_IF) ? rdata_q : '0;
  assign bus.ls_rdata   = (rsp_owner_q == OWN_LS) ? rdata_q : '0;

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] perf_conflict_q, perf_conflict_d;
  logic [31:0] perf_if_stall_q, perf_if_stall_d;

  always_comb begin
    perf_conflict_d = perf_conflict_q + 32'(bus.if_req & bus.ls_req);
    perf_if_stall_d = perf_if_stall_q + 32'(bus.if_req & ~if_gnt);
  end

  always_ff @(posedge clka or posedge rstb) begin
    if (rstb) begin
      perf_conflict_q <= '0;
      perf_if_stall_q <= '0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
      perf_if_stall_q <= perf_if_stall_d;
    end
  end

  assign perf_conflict = perf_conflict_q;
  assign perf_if_stall = perf_if_stall_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small ROM-style SRAM model.
// Perf counter checks are compiled in when SRAM_ARB_PERF_EN is defined.
module tb_sram_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_STARVE = 4;

  logic clka = 1'b0;
  logic rstb = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic exp_if;
  logic prev_if;

  always #5 clka = ~clka;

  sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] perf_conflict, perf_if_stall;
`endif

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STARVE(MAX_STARVE)) dut (
    .clka(clka),
    .rstb(rstb),
    .bus(bus)
`ifdef SRAM_ARB_PERF_EN
    ,
    .perf_conflict(perf_conflict),
    .perf_if_stall(perf_if_stall)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd3:   mem_word = 32'h2124_000A;
      32'd7:   mem_word = 32'hCAFE_0007;
      default: mem_word = 32'h5A5A_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  assign bus.sram_douta = mem_word(bus.sram_addra);

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;
    #1 rstb = 1'b1;
    #1;
    check1 ("rst_if_rvalid", bus.if_rvalid, 1'b0);
    check1 ("rst_ls_rvalid", bus.ls_rvalid, 1'b0);
    check32("rst_if_rdata",  bus.if_rdata, 32'h0);
    check32("rst_ls_rdata",  bus.ls_rdata, 32'h0);
    check1 ("rst_if_gnt",    bus.if_gnt, 1'b0);
    check1 ("rst_wea",       bus.sram_wea, 1'b0);
    check32("rst_addra",     bus.sram_addra, 32'h0);

    @(negedge clka); rstb = 1'b0;

    // IF-only read
    @(negedge clka); bus.if_req = 1'b1; bus.if_addr = 32'd3; #1;
    check1 ("ifrd_if_gnt", bus.if_gnt, 1'b1);
    check1 ("ifrd_ls_gnt", bus.ls_gnt, 1'b0);
    check32("ifrd_addra",  bus.sram_addra, 32'd3);
    check1 ("ifrd_wea",    bus.sram_wea, 1'b0);
    @(negedge clka); bus.if_req = 1'b0; bus.if_addr = '0; #1;
    check1 ("ifrd_rvalid",    bus.if_rvalid, 1'b1);
    check32("ifrd_rdata",     bus.if_rdata, 32'h2124_000A);
    check1 ("ifrd_ls_rvalid", bus.ls_rvalid, 1'b0);
    check32("ifrd_ls_rdata",  bus.ls_rdata, 32'h0);
    check32("idle_addra",     bus.sram_addra, 32'h0);
    @(negedge clka); #1;
    check1 ("ifrd_rvalid_off", bus.if_rvalid, 1'b0);
    check32("ifrd_rdata_off",  bus.if_rdata, 32'h0);

    // LS write
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'd5; bus.ls_wdata = 32'hDEAD_BEEF; #1;
    check1 ("lswr_wea",    bus.sram_wea, 1'b1);
    check32("lswr_waddr",  bus.sram_waddr, 32'd5);
    check32("lswr_dina",   bus.sram_dina, 32'hDEAD_BEEF);
    check1 ("lswr_ls_gnt", bus.ls_gnt, 1'b1);
    check1 ("lswr_if_gnt", bus.if_gnt, 1'b0);
    @(negedge clka); bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0; #1;
    check1 ("lswr_no_rvalid", bus.ls_rvalid, 1'b0);
    check1 ("lswr_if_rvalid", bus.if_rvalid, 1'b0);
    check1 ("idle_wea",       bus.sram_wea, 1'b0);
    check32("idle_dina",      bus.sram_dina, 32'h0);

    // LS write collides with IF read: LS first, IF retries next cycle
    bus.if_req = 1'b1; bus.if_addr = 32'd3;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'd9; bus.ls_wdata = 32'h1234_5678; #1;
    check1 ("wrcf_ls_gnt", bus.ls_gnt, 1'b1);
    check1 ("wrcf_if_gnt", bus.if_gnt, 1'b0);
    check1 ("wrcf_wea",    bus.sram_wea, 1'b1);
    check32("wrcf_waddr",  bus.sram_waddr, 32'd9);
    @(negedge clka); bus.ls_req = 1'b0; bus.ls_we = 1'b0; #1;
    check1 ("wrcf_retry_gnt",  bus.if_gnt, 1'b1);
    check32("wrcf_retry_addr", bus.sram_addra, 32'd3);
    check1 ("wrcf_ls_rvalid",  bus.ls_rvalid, 1'b0);
    @(negedge clka); bus.if_req = 1'b0; #1;
    check1 ("wrcf_if_rvalid", bus.if_rvalid, 1'b1);
    check32("wrcf_if_rdata",  bus.if_rdata, 32'h2124_000A);

    // Reset while an IF response is pending
    @(negedge clka); bus.if_req = 1'b1; bus.if_addr = 32'd7; #1;
    check1 ("rstop_gnt", bus.if_gnt, 1'b1);
    @(negedge clka); bus.if_req = 1'b0; #1;
    check1 ("rstop_rvalid_pre", bus.if_rvalid, 1'b1);
    check32("rstop_rdata_pre",  bus.if_rdata, 32'hCAFE_0007);
    #1 rstb = 1'b1; #1;
    check1 ("rstop_rvalid_async", bus.if_rvalid, 1'b0);
    check32("rstop_rdata_async",  bus.if_rdata, 32'h0);
    check32("rstop_starve",       32'(dut.starve_cnt_q), 32'h0);
    @(negedge clka); rstb = 1'b0; #1;
    check1 ("rstop_rvalid_rel", bus.if_rvalid, 1'b0);
    @(negedge clka); #1;
    check1 ("rstop_rvalid_after", bus.if_rvalid, 1'b0);
    check1 ("rstop_ls_after",     bus.ls_rvalid, 1'b0);

    // Continuous conflict: IF gets cycles 4 and 9
    @(negedge clka);
    bus.if_req = 1'b1; bus.if_addr = 32'd3;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'd7;
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_if = (c == 4) || (c == 9);
      check1("conf_if_gnt", bus.if_gnt, exp_if);
      check1("conf_ls_gnt", bus.ls_gnt, !exp_if);
      if (c > 0) begin
        prev_if = (c == 5);
        check1 ("conf_if_rvalid", bus.if_rvalid, prev_if);
        check1 ("conf_ls_rvalid", bus.ls_rvalid, !prev_if);
        check32("conf_ls_rdata",  bus.ls_rdata, prev_if ? 32'h0 : 32'hCAFE_0007);
        check32("conf_if_rdata",  bus.if_rdata, prev_if ? 32'h2124_000A : 32'h0);
      end
      @(negedge clka);
    end
    #1;
    check1 ("conf_tail_if_rvalid", bus.if_rvalid, 1'b1);
    check32("conf_tail_if_rdata",  bus.if_rdata, 32'h2124_000A);
    check1 ("conf_tail_ls_gnt",    bus.ls_gnt, 1'b1);
`ifdef SRAM_ARB_PERF_EN
    check32("perf_conflict", perf_conflict, 32'd10);
    check32("perf_if_stall", perf_if_stall, 32'd8);
`endif
    @(negedge clka); #1;
    check32("conf_starve_one",  32'(dut.starve_cnt_q), 32'd1);
    check1 ("conf_tail_ls_rv",  bus.ls_rvalid, 1'b1);
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    rstb = 1'b1; #1;
    check32("rst2_starve",    32'(dut.starve_cnt_q), 32'h0);
    check1 ("rst2_ls_rvalid", bus.ls_rvalid, 1'b0);
    check32("rst2_ls_rdata",  bus.ls_rdata, 32'h0);
`ifdef SRAM_ARB_PERF_EN
    check32("rst2_perf_conflict", perf_conflict, 32'h0);
    check32("rst2_perf_if_stall", perf_if_stall, 32'h0);
`endif
    @(negedge clka); rstb = 1'b0;
    @(negedge clka); #1;
    check1("rst2_after_ls", bus.ls_rvalid, 1'b0);
    check1("rst2_after_if", bus.if_rvalid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Arbitrates the single SRAM port (32-bit words, combinational read, write port wea/waddr/dina) between the MIPS instruction-fetch requester (IF) and the load/store requester (LS).
- Fixed LS priority, with a starvation guard for IF.
- Read data is registered, so each requester sees a one-cycle read latency.
- Sits between the core pipeline and the SRAM wrapper; no other master drives the SRAM.

Parameters:
ADDR_W, 32, address width of requesters and SRAM.
DATA_W, 32, data width.
MAX_STARVE, 4, consecutive denied IF cycles after which IF wins the next conflict; legal range 1..15.

Ports:
clka  in  1  clock; all state on rising edge
rstb  in  1  reset, asynchronous, active-high
if_req  in  1  IF read request
if_addr  in  ADDR_W  IF read address
if_gnt  out  1  IF request accepted this cycle
if_rvalid  out  1  IF read data valid
if_rdata  out  DATA_W  IF read data
ls_req  in  1  LS request
ls_we  in  1  LS write (1) / read (0)
ls_addr  in  ADDR_W  LS address
ls_wdata  in  DATA_W  LS write data
ls_gnt  out  1  LS request accepted this cycle
ls_rvalid  out  1  LS read data valid
ls_rdata  out  DATA_W  LS read data
sram_wea  out  1  SRAM write enable
sram_waddr  out  ADDR_W  SRAM write address
sram_dina  out  DATA_W  SRAM write data
sram_addra  out  ADDR_W  SRAM read address
sram_douta  in  DATA_W  SRAM read data (combinational from sram_addra)

Behaviour:
- Reset (rstb=1, async): rsp_owner=NONE, starve_cnt=0, rdata_q=0. if_rvalid, ls_rvalid, if_rdata and ls_rdata all read 0. Grants are combinational and follow the req inputs.
- Grant rule (combinational, same cycle as req):
  - Only one requester asks: it is granted.
  - Both ask: LS wins, unless starve_cnt==MAX_STARVE, in which case IF wins.
  - At most one gnt is high per cycle.
- SRAM drive (combinational):
  - A granted requester drives sram_addra and sram_waddr with its address.
  - sram_wea = ls_gnt & ls_we; sram_dina = ls_wdata.
  - Idle cycle: addresses, dina and wea are all 0.
  - IF never writes.
- Transaction completion: a request completes in the cycle its gnt is high. The requester may change req/addr on the next cycle.
- Response FSM (rsp_owner), updated on each clock edge:
  - NONE -> IF on an IF grant.
  - NONE -> LS on an LS read grant.
  - An LS write grant, or no grant, -> NONE.
  - From IF or LS, the same rules apply every cycle, so back-to-back reads are supported with no bubble.
- Read latency:
  - rdata_q <= sram_douta on any read grant.
  - In the cycle after the grant, {if,ls}_rvalid = (rsp_owner=={IF,LS}) and {if,ls}_rdata = rdata_q.
  - The non-owner's rdata reads 0.
- Writes produce no rvalid.
- Starvation counter (saturating, 4 bits):
  - if_req & !if_gnt: increment, saturating at MAX_STARVE.
  - if_gnt or !if_req: clear to 0.
- Boundaries:
  - Reset asserted with a read response pending: the response is dropped and rvalid stays 0 after release.
  - LS write and IF read in the same cycle: LS wins (outside starvation); IF retries.
  - Address values are passed through unmodified. Any wrap-around or low-bit decode is the SRAM's responsibility.

Optional Feature:
Macro SRAM_ARB_PERF_EN.
- Defined: adds two 32-bit output ports.
  - perf_conflict counts cycles with if_req & ls_req.
  - perf_if_stall counts cycles with if_req & !if_gnt.
  - Both wrap at 2^32, clear on reset, and are otherwise free-running.
- Undefined: the ports and counters are absent, and arbitration behaviour is identical.

Test Plan:
- Reset check: assert rstb mid-cycle -> if_rvalid=ls_rvalid=0 and if_rdata=ls_rdata=0 immediately (async), with no clock edge needed.
- IF-only read: if_req=1, if_addr=3 for one cycle -> if_gnt=1 and sram_addra=3 that cycle; next cycle if_rvalid=1, if_rdata=mem[3]=0x2124000A, ls_rvalid=0.
- Conflict/starvation (MAX_STARVE=4): if_req=ls_req=1 continuously, LS reads addr 7 -> ls_gnt in cycles 0-3, if_gnt in cycle 4, ls_gnt again in cycles 5-8, if_gnt in cycle 9. ls_rvalid/if_rvalid follow one cycle behind each grant.
- LS write: ls_req=1, ls_we=1, ls_addr=5, ls_wdata=0xDEADBEEF -> same cycle sram_wea=1, sram_waddr=5, sram_dina=0xDEADBEEF, ls_gnt=1; next cycle ls_rvalid=0.
- Reset mid-op: grant an IF read at cycle N, assert rstb during cycle N+1 -> if_rvalid drops to 0 at once, starve_cnt=0, and no rvalid after release.
- SRAM_ARB_PERF_EN defined: 10 cycles of dual request, MAX_STARVE=4 -> perf_conflict=10, perf_if_stall=8.
